// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Loads a word, then shifts it out serially over W cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int W = 8
) (
  input  logic         c,
  input  logic         nrst,
  input  logic         start,
  input  logic         dir,
  input  logic         abort,
  input  logic [W-1:0] d,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         sout,
  output logic         l,
  output logic         r,
  output logic         ready,
  output logic         busy,
  output logic         done
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] c_last = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic          r_dir;
  logic          w_l;
  logic          w_r;

  // Register mode is a function of state plus live start/abort.
  always_comb begin
    w_l = 1'b0;
    w_r = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_l = start;
        w_r = start;
      end
      S_SHIFT: begin
        if (!abort) begin
          w_l = ~r_dir;
          w_r = r_dir;
        end
      end
      default: begin
        w_l = 1'b0;
        w_r = 1'b0;
      end
    endcase
  end

  always_ff @(posedge c) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      case ({w_l, w_r})
        2'b11:   r_q <= d;
        2'b10:   r_q <= {sin, r_q[W-1:1]};
        2'b01:   r_q <= {r_q[W-2:0], sin};
        default: r_q <= r_q;
      endcase

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dir   <= dir;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (r_cnt == c_last) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign q     = r_q;
  assign sout  = r_dir ? r_q[W-1] : r_q[0];
  assign l     = w_l;
  assign r     = w_r;
  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// Testbench for shift_sequencer: random and directed transfers checked by a
// scoreboard fed from a bit-list model of the transfer.
module tb_shift_sequencer;

  localparam int W = 8;

  logic         c = 1'b0;
  logic         nrst;
  logic         start;
  logic         dir;
  logic         abort;
  logic [W-1:0] d;
  logic         sin;
  logic [W-1:0] q;
  logic         sout;
  logic         l;
  logic         r;
  logic         ready;
  logic         busy;
  logic         done;

  shift_sequencer #(.W(W)) dut (
    .c     (c),
    .nrst  (nrst),
    .start (start),
    .dir   (dir),
    .abort (abort),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .sout  (sout),
    .l     (l),
    .r     (r),
    .ready (ready),
    .busy  (busy),
    .done  (done)
  );

  always #5 c = ~c;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] so;
    logic         done;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   active = 1'b0;
  int   j = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The transfer is a stream: d bits in output order, followed by the sin bits.
  // After n shifts the register is a W-bit window starting at stream[n].
  function automatic exp_t model(input logic [W-1:0] dd, input logic dr,
                                 input logic [W-1:0] s, input int mode, input int at);
    exp_t m;
    bit   lst[2*W];
    int   n;
    for (int k = 0; k < W; k++) begin
      lst[k]     = dr ? dd[W-1-k] : dd[k];
      lst[W + k] = s[k];
    end
    n = (mode == 0) ? W : at - 1;
    for (int k = 0; k < W; k++) begin
      m.so[k] = lst[k];
      if (dr) m.q[W-1-k] = lst[n + k];
      else    m.q[k]     = lst[n + k];
    end
    if (mode == 2) m.q = '0;
    m.done = (mode == 0);
    return m;
  endfunction

  always @(negedge c) begin
    if (active) begin
      if (done) begin
        check("done_flag", done, cur.done);
        check("final_q", q, cur.q);
        check("done_lr", {l, r}, 2'b00);
        active = 1'b0;
      end else if (ready) begin
        check("done_flag", done, cur.done);
        check("final_q", q, cur.q);
        active = 1'b0;
      end else begin
        if (j < W) check("sout", sout, cur.so[j]);
        else       check("shift_count", j, W - 1);
        j++;
      end
    end else if (busy && !done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_accept: got busy=1 expected idle at %0t", $time);
      end else begin
        cur    = sb.pop_front();
        active = 1'b1;
        check("sout", sout, cur.so[0]);
        j = 1;
      end
    end else if (done) begin
      vectors++;
      miscompares++;
      $display("FAIL spurious_done: got done=1 expected 0 at %0t", $time);
    end
  end

  // mode: 0 normal, 1 abort in SHIFT cycle 'at', 2 reset in SHIFT cycle 'at'
  task automatic txn(input logic [W-1:0] dd, input logic dr, input logic [W-1:0] s,
                     input int mode, input int at, input bit hold);
    sb.push_back(model(dd, dr, s, mode, at));
    start = 1'b1;
    d     = dd;
    dir   = dr;
    abort = 1'($urandom);
    sin   = 1'($urandom);
    @(negedge c);
    check("accept_ready", ready, 1);
    check("accept_lr", {l, r}, 2'b11);
    @(posedge c); #1;
    for (int m = 1; m <= W; m++) begin
      sin   = s[m-1];
      start = hold | 1'($urandom);
      d     = W'($urandom);
      dir   = 1'($urandom);
      abort = (mode == 1) && (m == at);
      nrst  = !((mode == 2) && (m == at));
      @(negedge c);
      check("shift_lr", {l, r}, abort ? 2'b00 : (dr ? 2'b01 : 2'b10));
      @(posedge c); #1;
      if (mode != 0 && m == at) break;
    end
    abort = 1'b0;
    nrst  = 1'b1;
    if (mode == 0) begin
      abort = 1'($urandom);
      start = hold | 1'($urandom);
      @(posedge c); #1;
      abort = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    nrst  = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    dir   = 1'b1;
    d     = '1;
    sin   = 1'b1;
    repeat (2) @(posedge c);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge c);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lr", {l, r}, 2'b00);
    check("rst_sout", sout, 0);
    check("rst_q", q, 0);
    @(posedge c); #1;
    nrst = 1'b1;
    @(posedge c); #1;

    txn(8'h12, 1'b0, 8'hFF, 0, 0, 1'b0);
    txn(8'h12, 1'b1, 8'h00, 0, 0, 1'b0);
    txn(8'hA7, 1'b0, 8'hA7, 0, 0, 1'b0);   // loopback, dir=0
    txn(8'hA7, 1'b1, 8'hE5, 0, 0, 1'b0);   // loopback, dir=1 (sin order reversed)
    txn(8'hF0, 1'b0, 8'h00, 1, 3, 1'b1);
    txn(8'h12, 1'b0, 8'hFF, 2, 5, 1'b0);
    txn(8'h55, 1'b0, W'($urandom), 0, 0, 1'b0);
    txn(8'h3C, 1'b1, 8'h0F, 1, W, 1'b1);   // abort on the final shift
    repeat (4) txn(W'($urandom), 1'($urandom), W'($urandom), 0, 0, 1'b1);

    repeat (60) begin
      int sel;
      int mode;
      sel  = $urandom_range(0, 9);
      mode = (sel < 6) ? 0 : (sel < 8) ? 1 : 2;
      txn(W'($urandom), 1'($urandom), W'($urandom), mode,
          $urandom_range(1, W), 1'($urandom));
    end

    begin
      int waited;
      waited = 0;
      while ((sb.size() != 0 || active) && waited < 50) begin
        @(posedge c);
        waited++;
      end
      if (sb.size() != 0 || active) begin
        vectors++;
        miscompares++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
    end
    repeat (2) @(posedge c);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
